keypad_scan_queue: RTL
======================

# keypad_scan_queue

Parametrised matrix-keypad scanner with per-key debounce, ghost-key rejection and a key-event FIFO. It sits between the physical keypad pins and the general controller. The controller drains key codes through a ready/read handshake, so presses arriving while the controller is busy are queued rather than lost. Keycode decoding (digit/operator/equal) stays downstream; this block emits raw linear key indices.

## Interface
- ROWS, 4, number of keypad rows (inputs, active-low, pulled up)
- COLS, 4, number of keypad columns (outputs, driven low one at a time); ROWS*COLS >= 2
- SETTLE, 2, cycles a column is driven before its rows are sampled; >= 1
- DEBOUNCE, 10, consecutive identical samples required for press and for release; >= 2
- FIFO_DEPTH, 4, key-event queue entries; >= 2
- KW = $clog2(ROWS*COLS) (derived), CW = $clog2(FIFO_DEPTH+1) (derived)

- clk  in  1  system clock; the only clock
- nRST  in  1  reset, synchronous, active-low
- RowIn  in  ROWS  keypad rows; 0 = contact on the driven column
- ColOut  out  COLS  exactly one bit low (the scanned column), others high
- KeyRdy  out  1  FIFO non-empty
- KeyRd  in  1  pop head entry; honoured only when KeyRdy=1
- KeyCode  out  KW  head entry = row*COLS + col; valid when KeyRdy=1
- Count  out  CW  entries currently queued
- Overflow  out  1  sticky: a debounced press was dropped because the FIFO was full
- ClrOvf  in  1  clears Overflow

## Operation
- Reset (nRST=0 at a clk edge): state SCAN, column 0, settle/debounce counters 0, FIFO flushed. Outputs: ColOut = all ones except bit 0 low, KeyRdy=0, KeyCode=0, Count=0, Overflow=0. Reset mid-debounce or mid-release discards the pending key.
- States:
  - SCAN: drive the current column for SETTLE cycles, then one sample cycle.
    - Sample with no row low: advance to the next column (COLS-1 wraps to 0) and restart settle.
    - Sample with more than one row low: ghost/multi-key. Treat as no press and advance.
    - Sample with exactly one row low: latch the row and column, set the debounce count to 1, go to DEBOUNCE.
  - DEBOUNCE: column held. Each cycle:
    - Same single row low: increment the count. At count == DEBOUNCE, go to PUSH.
    - Any other pattern: return to SCAN on the same column with settle restarted. Nothing is pushed.
  - PUSH: one cycle. Write the latched code into the FIFO. If the FIFO is full and not popped this cycle, drop the code and set Overflow. Go to RELEASE.
  - RELEASE: column held. RowIn must read all ones for DEBOUNCE consecutive cycles; any low bit resets the count. Then go to SCAN on the next column. A held key therefore yields exactly one event, with no auto-repeat.
- FIFO: circular buffer with wrapping read/write pointers.
  - A pop occurs at a clk edge when KeyRd && KeyRdy. KeyRd while empty is ignored; Count does not underflow.
  - Push and pop in the same cycle while full: both happen, no overflow, Count unchanged.
  - Push and pop in the same cycle with Count=1: Count stays 1 and KeyCode becomes the new entry.
- Overflow is set by a dropped push and cleared by ClrOvf. If both occur in the same cycle, set wins. Overflow does not clear on pop.

## Timing
- Sample cycle at edge t with a single press: DEBOUNCE state occupies cycles t+1 .. t+DEBOUNCE-1. PUSH is at t+DEBOUNCE. KeyRdy/KeyCode/Count update at edge t+DEBOUNCE+1.
- Worst-case scan period (no keys pressed) = COLS*(SETTLE+1) cycles.
- ColOut changes only on SCAN column advance, registered. It is glitch-free and stable throughout DEBOUNCE, PUSH and RELEASE.
- KeyCode/KeyRdy/Count are registered or pure functions of registered state. A pop at edge e presents the next entry (or KeyRdy=0) after e.

## Test plan
Settings for all scenarios: ROWS=COLS=4, SETTLE=2, DEBOUNCE=4, FIFO_DEPTH=4.
- Reset then idle (RowIn=4'hF), 24 cycles -> ColOut cycles 1110,1101,1011,0111 every 3 cycles; KeyRdy=0, Count=0.
- Hold row 2 low while column 1 is driven, for 20 cycles, then release -> exactly one entry, KeyCode=9, KeyRdy rises 5 cycles after the sample edge; pulse KeyRd -> KeyRdy=0.
- Bounce: row 0 low for 2 cycles, high for 1, low for 2, repeated -> no push. Then a stable press -> one push.
- Ghost: rows 0 and 3 both low on column 2 -> scan keeps advancing, Count stays 0.
- Five distinct presses without KeyRd -> Count=4, Overflow=1, first four codes in order. ClrOvf -> Overflow=0. Sixth press with a simultaneous KeyRd on a full FIFO -> no overflow, Count=4.
- nRST=0 during RELEASE with Count=2 -> next cycle: Count=0, KeyRdy=0, ColOut=1110, Overflow=0.

Source files
------------

// File: rtl/keypad_scan_if.sv
// Keypad-side and controller-side signals of the keypad scanner, bundled.
// The scanner takes the slave view; the controller/keypad side takes master.
interface keypad_scan_if #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int KW = $clog2(ROWS * COLS);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [ROWS-1:0] RowIn;     // active-low rows, pulled up
  logic [COLS-1:0] ColOut;    // exactly one bit low: the scanned column
  logic            KeyRdy;    // queue non-empty
  logic            KeyRd;     // pop head entry
  logic [KW-1:0]   KeyCode;   // head entry = row*COLS + col
  logic [CW-1:0]   Count;     // entries queued
  logic            Overflow;  // sticky: a press was dropped
  logic            ClrOvf;    // clears Overflow

  modport slave (
    input  RowIn, KeyRd, ClrOvf,
    output ColOut, KeyRdy, KeyCode, Count, Overflow
  );

  modport master (
    output RowIn, KeyRd, ClrOvf,
    input  ColOut, KeyRdy, KeyCode, Count, Overflow
  );
endinterface

// File: rtl/keypad_scan_queue.sv
// Matrix-keypad scanner: column scan with settle time, single-key debounce on
// press and release, ghost/multi-key rejection, and a key-event FIFO drained
// by the controller through KeyRdy/KeyRd.
module keypad_scan_queue #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SETTLE     = 2,
  parameter int DEBOUNCE   = 10,
  parameter int FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          nRST,
  keypad_scan_if.slave bus
);
  localparam int KW  = $clog2(ROWS * COLS);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW  = $clog2(SETTLE + 1);
  localparam int DW  = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PUSH, S_RELEASE} state_t;

  state_t          state_q, state_d;
  logic [CIW-1:0]  col_q, col_d, col_next;
  logic [RIW-1:0]  row_q, row_d, low_idx;
  logic [SW-1:0]   settle_q, settle_d;
  logic [DW-1:0]   deb_q, deb_d;
  logic [COLS-1:0] col_out_q;
  logic [ROWS-1:0] low, held_pat;
  logic            single_low, push;
  logic [KW-1:0]   push_code;

  logic [KW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count_q;
  logic            ovf_q, full, empty, pop, do_push, drop;

  // Row decode: which rows are low, and whether exactly one is.
  always_comb begin
    low        = ~bus.RowIn;
    single_low = (low != '0) && ((low & (low - ROWS'(1))) == '0);
    low_idx    = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (low[r]) low_idx = RIW'(r);
    end
    held_pat  = ~(ROWS'(1) << row_q);
    col_next  = (col_q == CIW'(COLS - 1)) ? '0 : col_q + CIW'(1);
    push_code = KW'(row_q) * KW'(COLS) + KW'(col_q);
  end

  // Scan FSM next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    settle_d = settle_q;
    deb_d    = deb_q;
    push     = 1'b0;
    case (state_q)
      S_SCAN: begin
        if (settle_q == SW'(SETTLE)) begin
          settle_d = '0;
          if (single_low) begin
            row_d   = low_idx;
            deb_d   = DW'(1);
            state_d = S_DEBOUNCE;
          end else begin
            col_d = col_next;  // idle or ghost pattern: move on
          end
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_DEBOUNCE: begin
        if (bus.RowIn == held_pat) begin
          deb_d = deb_q + DW'(1);
          if (deb_q + DW'(1) == DW'(DEBOUNCE)) state_d = S_PUSH;
        end else begin
          settle_d = '0;
          state_d  = S_SCAN;
        end
      end
      S_PUSH: begin
        push    = 1'b1;
        deb_d   = '0;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (&bus.RowIn) begin
          deb_d = deb_q + DW'(1);
          if (deb_q + DW'(1) == DW'(DEBOUNCE)) begin
            deb_d    = '0;
            settle_d = '0;
            col_d    = col_next;
            state_d  = S_SCAN;
          end
        end else begin
          deb_d = '0;  // key still down: restart the release count
        end
      end
      default: state_d = S_SCAN;
    endcase
  end

  // Scan FSM registers; ColOut is registered so it never glitches.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!nRST) begin
      state_q   <= S_SCAN;
      col_q     <= '0;
      row_q     <= '0;
      settle_q  <= '0;
      deb_q     <= '0;
      col_out_q <= ~COLS'(1);
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      settle_q  <= settle_d;
      deb_q     <= deb_d;
      col_out_q <= ~(COLS'(1) << col_d);
    end
  end

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = bus.KeyRd && !empty;
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; KeyCode is masked while empty, so stale contents are never visible.
    if (do_push) mem[wr_ptr] <= push_code;
  end

  // FIFO pointers, occupancy and sticky overflow flag (set beats clear).
  always_ff @(posedge clk) begin
    if (!nRST) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)     rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (do_push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !do_push) count_q <= count_q - CW'(1);
      if (drop)            ovf_q <= 1'b1;
      else if (bus.ClrOvf) ovf_q <= 1'b0;
    end
  end

  assign bus.ColOut   = col_out_q;
  assign bus.KeyRdy   = !empty;
  assign bus.KeyCode  = empty ? '0 : mem[rd_ptr];
  assign bus.Count    = count_q;
  assign bus.Overflow = ovf_q;
endmodule
